// File: rtl/decoder_pkg.sv
// decoder_pkg: shared opcode, funct7 and ALU constants plus the
// control FSM state encoding used by alu_op_decode and ctrl_fsm.
package decoder_pkg;

    localparam logic [6:0] RALU    = 7'b0110011;
    localparam logic [6:0] IALU    = 7'b0010011;
    localparam logic [6:0] ILOAD   = 7'b0000011;
    localparam logic [6:0] SSTORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [4:0] ALU_ADD = 5'd0;

    typedef enum logic [2:0] {
        DECODE,
        MEM_WAIT,
        LOAD_WB,
        MULDIV,
        TRAP
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode/funct3/funct7 decode.
// Ports: opcode, funct3, funct7 in; alu_op, shifti, imm, legal,
//        is_mem, is_store, is_mop out.
module alu_op_decode
    import decoder_pkg::*;
#(
    parameter int ALUOP_W = 5,
    parameter int EN_MEXT = 1
) (
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               shifti,
    output logic               imm,
    output logic               legal,
    output logic               is_mem,
    output logic               is_store,
    output logic               is_mop
);

    // Native 5-bit encoding {mext, funct3, alt}, resized to ALUOP_W.
    logic [4:0] op5;

    always_comb begin
        op5      = 5'd0;
        shifti   = 1'b0;
        imm      = 1'b0;
        legal    = 1'b0;
        is_mem   = 1'b0;
        is_store = 1'b0;
        is_mop   = 1'b0;
        case (opcode)
            RALU: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    op5   = {1'b0, funct3, funct7[5]};
                    legal = 1'b1;
                end else if (EN_MEXT != 0 && funct7 == F7_MEXT) begin
                    op5    = {1'b1, funct3, 1'b0};
                    legal  = 1'b1;
                    is_mop = 1'b1;
                end
            end
            IALU: begin
                imm   = 1'b1;
                legal = 1'b1;
                // Only shifts use funct7[5] (srai vs srli); for the
                // other immediates those bits belong to the constant.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    op5    = {1'b0, funct3, funct7[5]};
                    shifti = 1'b1;
                end else begin
                    op5 = {1'b0, funct3, 1'b0};
                end
            end
            ILOAD: begin
                op5    = ALU_ADD;
                imm    = 1'b1;
                is_mem = 1'b1;
                legal  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                         (funct3 == 3'b010) || (funct3 == 3'b100) ||
                         (funct3 == 3'b101);
            end
            SSTORE: begin
                op5      = ALU_ADD;
                imm      = 1'b1;
                is_mem   = 1'b1;
                is_store = 1'b1;
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                           (funct3 == 3'b010);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign alu_op = ALUOP_W'(op5);

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit (decode, load/store, M-ops, trap).
// Ports: clock, reset, instr_valid, opcode, funct3, funct7, mem_ready in;
//        AluOp, regw, incr, imm, shifti, memr, memw, memsize, wbsel,
//        busy, fault out.
module ctrl_fsm
    import decoder_pkg::*;
#(
    parameter int ALUOP_W     = 5,
    parameter int EN_MEXT     = 1,
    parameter int MULDIV_LAT  = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               regw,
    output logic               incr,
    output logic               imm,
    output logic               shifti,
    output logic               memr,
    output logic               memw,
    output logic [2:0]         memsize,
    output logic               wbsel,
    output logic               busy,
    output logic               fault
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [7:0] MD_INIT = 8'(MULDIV_LAT - 1);

    logic [ALUOP_W-1:0] d_aluop;
    logic               d_shifti;
    logic               d_imm;
    logic               d_legal;
    logic               d_mem;
    logic               d_store;
    logic               d_mop;

    state_t             state;
    logic [7:0]         cnt;
    logic               ld_q;
    logic [ALUOP_W-1:0] mop_q;
    logic [2:0]         size_q;

    alu_op_decode #(
        .ALUOP_W (ALUOP_W),
        .EN_MEXT (EN_MEXT)
    ) u_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_op   (d_aluop),
        .shifti   (d_shifti),
        .imm      (d_imm),
        .legal    (d_legal),
        .is_mem   (d_mem),
        .is_store (d_store),
        .is_mop   (d_mop)
    );

    // One counter serves both the memory timeout (counts up)
    // and the M-op latency (counts down).
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= DECODE;
            cnt    <= 8'd0;
            ld_q   <= 1'b0;
            mop_q  <= '0;
            size_q <= 3'd0;
        end else begin
            case (state)
                DECODE: begin
                    if (instr_valid) begin
                        if (!d_legal) begin
                            state <= TRAP;
                        end else if (d_mem) begin
                            state  <= MEM_WAIT;
                            cnt    <= 8'd0;
                            ld_q   <= !d_store;
                            size_q <= funct3;
                        end else if (d_mop) begin
                            state <= MULDIV;
                            cnt   <= MD_INIT;
                            mop_q <= d_aluop;
                        end
                    end
                end
                MEM_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (mem_ready) begin
                        state <= ld_q ? LOAD_WB : DECODE;
                    end else if (cnt == TO_LAST) begin
                        state <= TRAP;
                    end
                end
                LOAD_WB: begin
                    state <= DECODE;
                end
                MULDIV: begin
                    if (cnt == 8'd0) begin
                        state <= DECODE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= TRAP;
                end
            endcase
        end
    end

    // Outputs depend on the live instruction in DECODE, and reset
    // must silence them in the same cycle, so they are combinational.
    always_comb begin
        AluOp   = '0;
        regw    = 1'b0;
        incr    = 1'b0;
        imm     = 1'b0;
        shifti  = 1'b0;
        memr    = 1'b0;
        memw    = 1'b0;
        memsize = 3'd0;
        wbsel   = 1'b0;
        busy    = 1'b0;
        fault   = 1'b0;
        if (!reset) begin
            case (state)
                DECODE: begin
                    if (instr_valid && d_legal) begin
                        AluOp  = d_aluop;
                        imm    = d_imm;
                        shifti = d_shifti;
                        if (d_mem) begin
                            memr    = !d_store;
                            memw    = d_store;
                            memsize = funct3;
                        end else if (!d_mop) begin
                            regw = 1'b1;
                            incr = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    busy    = 1'b1;
                    AluOp   = ALUOP_W'(ALU_ADD);
                    imm     = 1'b1;
                    memr    = ld_q;
                    memw    = !ld_q;
                    memsize = size_q;
                    incr    = mem_ready && !ld_q;
                end
                LOAD_WB: begin
                    busy  = 1'b1;
                    regw  = 1'b1;
                    wbsel = 1'b1;
                    incr  = 1'b1;
                end
                MULDIV: begin
                    busy  = 1'b1;
                    AluOp = mop_q;
                    regw  = (cnt == 8'd0);
                    incr  = (cnt == 8'd0);
                end
                TRAP: begin
                    // busy still reflects "not in DECODE" here.
                    busy  = 1'b1;
                    fault = 1'b1;
                end
                default: begin
                    busy = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: directed-vector bench for ctrl_fsm, with a second
// instance built without the M extension.
module tb_ctrl_fsm;
    import decoder_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_ready;

    logic [4:0] a_aluop, b_aluop;
    logic       a_regw, a_incr, a_imm, a_shifti, a_memr, a_memw;
    logic       a_wbsel, a_busy, a_fault;
    logic [2:0] a_memsize, b_memsize;
    logic       b_regw, b_incr, b_imm, b_shifti, b_memr, b_memw;
    logic       b_wbsel, b_busy, b_fault;
    logic [16:0] a_vec, b_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    ctrl_fsm #(
        .ALUOP_W(5), .EN_MEXT(1), .MULDIV_LAT(4), .MEM_TIMEOUT(16)
    ) dut_a (
        .clock(clock), .reset(reset), .instr_valid(instr_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .AluOp(a_aluop), .regw(a_regw),
        .incr(a_incr), .imm(a_imm), .shifti(a_shifti), .memr(a_memr),
        .memw(a_memw), .memsize(a_memsize), .wbsel(a_wbsel),
        .busy(a_busy), .fault(a_fault)
    );

    ctrl_fsm #(
        .ALUOP_W(5), .EN_MEXT(0), .MULDIV_LAT(4), .MEM_TIMEOUT(16)
    ) dut_b (
        .clock(clock), .reset(reset), .instr_valid(instr_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .AluOp(b_aluop), .regw(b_regw),
        .incr(b_incr), .imm(b_imm), .shifti(b_shifti), .memr(b_memr),
        .memw(b_memw), .memsize(b_memsize), .wbsel(b_wbsel),
        .busy(b_busy), .fault(b_fault)
    );

    assign a_vec = {a_aluop, a_regw, a_incr, a_imm, a_shifti, a_memr,
                    a_memw, a_memsize, a_wbsel, a_busy, a_fault};
    assign b_vec = {b_aluop, b_regw, b_incr, b_imm, b_shifti, b_memr,
                    b_memw, b_memsize, b_wbsel, b_busy, b_fault};

    // Field order: aluop regw incr imm shifti memr memw memsize wbsel busy fault
    function automatic logic [16:0] pk(
        input logic [4:0] op, input logic rw, input logic inc,
        input logic im, input logic sh, input logic mr, input logic mw,
        input logic [2:0] ms, input logic wb, input logic bsy,
        input logic flt
    );
        return {op, rw, inc, im, sh, mr, mw, ms, wb, bsy, flt};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [6:0] op,
                          input logic [2:0] f3, input logic [6:0] f7,
                          input logic rdy);
        instr_valid = v;
        opcode      = op;
        funct3      = f3;
        funct7      = f7;
        mem_ready   = rdy;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step2(input string tag, input logic [16:0] ea,
                         input logic [16:0] eb);
        #1;
        check(tag, 32'(a_vec), 32'(ea));
        check({tag, "_b"}, 32'(b_vec), 32'(eb));
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic step(input string tag, input logic [16:0] e);
        step2(tag, e, e);
    endtask

    localparam logic [16:0] ZERO = 17'd0;
    logic [16:0] trap_v;
    logic [16:0] sw_wait;

    initial begin
        trap_v  = pk(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 1);
        sw_wait = pk(0, 0, 0, 1, 0, 0, 1, 3'd1, 0, 1, 0);
        reset = 1'b1;
        set_in(1, RALU, 3'd0, F7_BASE, 1'b1);
        @(negedge clock);
        step("reset", ZERO);
        reset = 1'b0;

        set_in(1, RALU, 3'd0, F7_BASE, 0);
        step("add", pk(0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0));
        set_in(1, RALU, 3'd0, F7_ALT, 0);
        step("sub", pk(5'd1, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0));
        set_in(1, IALU, 3'd5, F7_ALT, 0);
        step("srai", pk(5'b01011, 1, 1, 1, 1, 0, 0, 3'd0, 0, 0, 0));
        set_in(1, IALU, 3'd0, F7_ALT, 0);
        step("addi", pk(5'd0, 1, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0));
        set_in(1, IALU, 3'd7, F7_ALT, 0);
        step("andi", pk(5'b01110, 1, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0));
        set_in(0, RALU, 3'd0, F7_BASE, 0);
        step("stall", ZERO);

        // lw, ready ignored at issue, then high on the 3rd wait cycle
        set_in(1, ILOAD, 3'd2, 7'd0, 1);
        step("lw_issue", pk(0, 0, 0, 1, 0, 1, 0, 3'd2, 0, 0, 0));
        set_in(1, ILOAD, 3'd0, 7'd0, 0);
        step("lw_wait1", pk(0, 0, 0, 1, 0, 1, 0, 3'd2, 0, 1, 0));
        step("lw_wait2", pk(0, 0, 0, 1, 0, 1, 0, 3'd2, 0, 1, 0));
        mem_ready = 1'b1;
        step("lw_wait3", pk(0, 0, 0, 1, 0, 1, 0, 3'd2, 0, 1, 0));
        mem_ready = 1'b0;
        step("lw_wb", pk(0, 1, 1, 0, 0, 0, 0, 3'd0, 1, 1, 0));
        set_in(0, RALU, 3'd0, F7_BASE, 0);
        step("lw_idle", ZERO);

        // sw that times out
        set_in(1, SSTORE, 3'd1, 7'd0, 0);
        step("sw_issue", pk(0, 0, 0, 1, 0, 0, 1, 3'd1, 0, 0, 0));
        for (int i = 0; i < 16; i++) step("sw_wait", sw_wait);
        set_in(1, RALU, 3'd0, F7_BASE, 0);
        for (int i = 0; i < 3; i++) step("sw_trap", trap_v);
        reset = 1'b1;
        step("trap_reset", ZERO);
        reset = 1'b0;

        // sw completing after one wait cycle
        set_in(1, SSTORE, 3'd0, 7'd0, 1);
        step("sw_issue2", pk(0, 0, 0, 1, 0, 0, 1, 3'd0, 0, 0, 0));
        step("sw_done", pk(0, 0, 1, 1, 0, 0, 1, 3'd0, 0, 1, 0));
        set_in(0, RALU, 3'd0, F7_BASE, 0);
        step("sw_idle", ZERO);

        // reset abandons an access in progress
        set_in(1, SSTORE, 3'd2, 7'd0, 0);
        step("sw_issue3", pk(0, 0, 0, 1, 0, 0, 1, 3'd2, 0, 0, 0));
        step("sw_wait3", pk(0, 0, 0, 1, 0, 0, 1, 3'd2, 0, 1, 0));
        reset = 1'b1;
        step("rst_mid", ZERO);
        reset = 1'b0;
        set_in(0, RALU, 3'd0, F7_BASE, 0);
        step("rst_decode", ZERO);

        // mul: 5 cycles on dut_a, illegal on dut_b
        set_in(1, RALU, 3'd0, F7_MEXT, 0);
        step2("mul_issue", pk(5'b10000, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0),
              ZERO);
        for (int i = 0; i < 3; i++)
            step2("mul_busy",
                  pk(5'b10000, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0), trap_v);
        step2("mul_done", pk(5'b10000, 1, 1, 0, 0, 0, 0, 3'd0, 0, 1, 0),
              trap_v);
        set_in(0, RALU, 3'd0, F7_BASE, 0);
        step2("mul_idle", ZERO, trap_v);
        reset = 1'b1;
        step("rst2", ZERO);
        reset = 1'b0;

        // illegal opcode
        set_in(1, 7'b1111111, 3'd0, 7'd0, 0);
        step("ill_issue", ZERO);
        set_in(0, RALU, 3'd0, F7_BASE, 0);
        step("ill_trap", trap_v);
        reset = 1'b1;
        step("rst3", ZERO);
        reset = 1'b0;

        // lw with illegal funct3
        set_in(1, ILOAD, 3'd3, 7'd0, 0);
        step("lw3_issue", ZERO);
        set_in(1, RALU, 3'd0, F7_BASE, 0);
        step("lw3_trap", trap_v);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
